seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector and the successor to the fixed 5-bit "10101" detector.
- Pattern width, pattern value and match mode (overlapping or non-overlapping) are set at build time or run time.
- Only valid-qualified bits are sampled.
- A fill guard stops false matches on reset-cleared history.
- Matches are counted in a saturating counter.
- Sits between a serial bit source and the lab display/LED logic.

Parameters:
PAT_W, 5, pattern length in bits (2..16)
CNT_W, 8, width of the match counter
DEF_PAT, 5'b10101 (PAT_W bits), pattern value applied at reset

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
x_valid  in  1  qualifies x; bit accepted only when high
x  in  1  serial data bit
pat_load  in  1  load pat_in as the new pattern this cycle
pat_in  in  PAT_W  new pattern value
overlap  in  1  1 = overlapping matches, 0 = non-overlapping
cnt_clr  in  1  clear match counter
z  out  1  registered one-cycle match pulse
seq  out  PAT_W  history register; newest bit in [0]
match_cnt  out  CNT_W  number of matches, saturating
cnt_sat  out  1  high while match_cnt is all-ones
armed  out  1  high when state is ARMED

Behaviour:
- Reset (rst=1 at posedge), which overrides everything:
  - seq=0, z=0, match_cnt=0, cnt_sat=0.
  - pattern register=DEF_PAT, fill=0, state=FILL, armed=0.
- Accepted bit: x_valid=1, pat_load=0, rst=0.
  - seq_next = {seq[PAT_W-2:0], x}.
  - seq updates at the same edge.
- z, zero-latency registered:
  - At the accepting edge, z<=1 iff state_next-check passes: state is ARMED after this bit (fill reaches PAT_W) and seq_next==pattern.
  - Otherwise z<=0.
  - z is never high two cycles from one accepted bit.
  - z=0 in any cycle following an edge with x_valid=0.
- State machine, states FILL and ARMED:
  - FILL: fill counts accepted bits. When an accepted bit makes fill==PAT_W, go to ARMED and evaluate the match on that same bit. No match can occur before PAT_W bits are accepted, even if the pattern is all-zeros.
  - ARMED: each accepted bit is compared against the pattern.
  - On a match in overlap=1: stay in ARMED.
  - On a match in overlap=0: clear seq to 0, set fill=0 and go to FILL at that edge. seq therefore shows 0 after the edge, while z=1.
- pat_load=1:
  - The pattern register takes pat_in.
  - seq=0, fill=0, state=FILL, z<=0.
  - If x_valid is also high, the bit is discarded because load wins.
  - match_cnt is unaffected.
- overlap is sampled per accepted bit. Changing it mid-stream affects only subsequent matches.
- match_cnt:
  - Increments on every z assertion and saturates at 2^CNT_W-1.
  - cnt_sat = (match_cnt == all-ones), registered alongside match_cnt.
  - cnt_clr=1 forces match_cnt=0.
  - If cnt_clr and a match occur in the same cycle, the result is 0: clear wins.
- x_valid=0: seq, fill and state hold; z<=0.
- Reset mid-stream discards partial history. The first match needs PAT_W new bits.

Optional Feature:
Macro: SEQ_DETECTOR_MASK_EN
- Defined:
  - Adds input pat_mask_in [PAT_W-1:0], loaded with pat_load. Reset value is all-ones.
  - A match requires ((seq_next ^ pattern) & mask)==0. Mask bit 0 means don't-care.
  - The fill guard still requires PAT_W accepted bits.
- Undefined: no port. Exact compare on all PAT_W bits.

Decomposition:
- Package seq_detector_pkg holds:
  - state typedef (FILL, ARMED) and the fill-counter width function clog2(PAT_W+1);
  - default pattern constant.
- Sub-module seq_det_shreg, generic PAT_W, holds the shift history with shift-enable and synchronous clear. The top module holds the FSM, compare and counter.

Test Plan:
- Reset with default pattern, overlap=1; feed 1,0,1,0,1,0,1 (valid every cycle) -> z=1 after the 5th and 7th bits only; match_cnt=2.
- Same stream with overlap=0 -> z=1 after the 5th bit only; seq=0 after the match; match_cnt=1.
- pat_load with pat_in=5'b00000, then 4 zeros -> z stays 0. The 5th zero -> z=1, showing the fill guard.
- Insert x_valid=0 gaps between the bits of 10101 -> single z pulse on the 5th accepted bit; seq unchanged during gaps.
- Run matches until match_cnt=255 (CNT_W=8) -> holds at 255 with cnt_sat=1. Assert cnt_clr in the same cycle as a match -> match_cnt=0.
- rst after 3 bits of 10101, then 0,1 -> no z. The full 10101 afterwards -> z=1.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
// Holds the FSM state type, fill-counter width helper and default pattern.
package seq_detector_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [4:0] SEQ_DEF_PAT = 5'b10101;

    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_shreg.sv
// Serial history register, newest bit in q[0].
// Shift-enable plus synchronous clear; clear beats shift.
module seq_det_shreg #(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             d,
    output logic [PAT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[PAT_W-2:0], d};
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with fill guard and match counter.
// Define SEQ_DETECTOR_MASK_EN to add a per-bit don't-care mask input.
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int               PAT_W   = 5,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic             x,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic [PAT_W-1:0] seq,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             armed
`ifdef SEQ_DETECTOR_MASK_EN
    ,
    input  logic [PAT_W-1:0] pat_mask_in
`endif
);

    localparam int            FW   = fill_w(PAT_W);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    state_t           state;
    state_t           state_nx;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nx;
    logic [FW-1:0]    fill_inc;
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] seq_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             acc;
    logic             arm_nx;
    logic             eq;
    logic             hit;
    logic             drop;
    logic             fill_go;

`ifdef SEQ_DETECTOR_MASK_EN
    logic [PAT_W-1:0] mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '1;
        end else if (pat_load) begin
            mask <= pat_mask_in;
        end
    end

    assign eq = ((seq_nx ^ pat) & mask) == '0;
`else
    assign eq = (seq_nx == pat);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pat <= DEF_PAT;
        end else if (pat_load) begin
            pat <= pat_in;
        end
    end

    seq_det_shreg #(
        .PAT_W(PAT_W)
    ) u_shreg (
        .clk(clk),
        .rst(rst),
        .en (acc),
        .clr(pat_load | drop),
        .d  (x),
        .q  (seq)
    );

    // Compare is made against the history as it will be after this bit.
    always_comb begin
        acc      = x_valid & ~pat_load;
        seq_nx   = {seq[PAT_W-2:0], x};
        fill_inc = fill + FW'(1);
        arm_nx   = (state == ARMED) || (fill_inc == FULL);
        hit      = acc & arm_nx & eq;
        drop     = hit & ~overlap;
        fill_go  = acc & (state == FILL) & ~drop;
        armed    = (state == ARMED);
    end

    always_comb begin
        state_nx = state;
        fill_nx  = fill;
        unique case (1'b1)
            pat_load: begin
                state_nx = FILL;
                fill_nx  = '0;
            end
            drop: begin
                state_nx = FILL;
                fill_nx  = '0;
            end
            fill_go: begin
                fill_nx = fill_inc;
                if (fill_inc == FULL) begin
                    state_nx = ARMED;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            fill  <= '0;
        end else begin
            state <= state_nx;
            fill  <= fill_nx;
        end
    end

    always_comb begin
        cnt_nx = match_cnt;
        if (cnt_clr) begin
            cnt_nx = '0;
        end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
            cnt_nx = match_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z         <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            z         <= hit;
            match_cnt <= cnt_nx;
            cnt_sat   <= &cnt_nx;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, hand-written corner
// sequences and random stimulus checked against a bit-history model.
module tb_seq_detector_param;

    localparam int         PAT_W = 5;
    localparam int         CNT_W = 8;
    localparam int         CMAX  = 255;
    localparam logic [4:0] DEF   = 5'b10101;

    logic             clk = 1'b0;
    logic             rst;
    logic             x_valid;
    logic             x;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             overlap;
    logic             cnt_clr;
    logic             z;
    logic [PAT_W-1:0] seq;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic             armed;

    seq_detector_param #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .x_valid  (x_valid),
        .x        (x),
        .pat_load (pat_load),
        .pat_in   (pat_in),
        .overlap  (overlap),
        .cnt_clr  (cnt_clr),
        .z        (z),
        .seq      (seq),
        .match_cnt(match_cnt),
        .cnt_sat  (cnt_sat),
        .armed    (armed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: list of bits accepted since the last clear of history.
    bit         hist[$];
    logic [4:0] mpat = DEF;
    int         mcnt = 0;
    bit         mz   = 1'b0;

    typedef struct {
        bit         r;
        bit         xv;
        bit         xb;
        bit         pl;
        logic [4:0] pi;
        bit         ov;
        bit         cc;
        bit         ez;
        int         ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [4:0] tail();
        logic [4:0] t;
        t = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (hist.size() > i) t[i] = hist[hist.size() - 1 - i];
        end
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit xv, input bit xb,
                         input bit pl, input logic [4:0] pi,
                         input bit ov, input bit cc);
        if (r) begin
            hist.delete();
            mpat = DEF;
            mz   = 1'b0;
            mcnt = 0;
        end else begin
            mz = 1'b0;
            if (pl) begin
                mpat = pi;
                hist.delete();
            end else if (xv) begin
                hist.push_back(xb);
                if (hist.size() >= PAT_W && tail() == mpat) begin
                    mz = 1'b1;
                    if (!ov) hist.delete();
                end
                if (hist.size() > 8) void'(hist.pop_front());
            end
            if (cc) mcnt = 0;
            else if (mz && mcnt < CMAX) mcnt++;
        end
    endtask

    task automatic step(input string tag, input bit r, input bit xv,
                        input bit xb, input bit pl, input logic [4:0] pi,
                        input bit ov, input bit cc);
        rst      = r;
        x_valid  = xv;
        x        = xb;
        pat_load = pl;
        pat_in   = pi;
        overlap  = ov;
        cnt_clr  = cc;
        @(posedge clk);
        #1;
        model(r, xv, xb, pl, pi, ov, cc);
        chk({tag, "_z"}, 32'(z), 32'(mz));
        chk({tag, "_seq"}, 32'(seq), 32'(tail()));
        chk({tag, "_cnt"}, 32'(match_cnt), 32'(mcnt));
        chk({tag, "_sat"}, 32'(cnt_sat), 32'(mcnt == CMAX));
        chk({tag, "_armed"}, 32'(armed), 32'(hist.size() >= PAT_W));
    endtask

    task automatic row(input bit r, input bit xv, input bit xb,
                       input bit pl, input logic [4:0] pi, input bit ov,
                       input bit cc, input bit ez, input int ecnt);
        vec_t v;
        v.r    = r;
        v.xv   = xv;
        v.xb   = xb;
        v.pl   = pl;
        v.pi   = pi;
        v.ov   = ov;
        v.cc   = cc;
        v.ez   = ez;
        v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic bit_row(input bit xb, input bit ov, input bit ez,
                           input int ecnt);
        row(0, 1, xb, 0, 5'd0, ov, 0, ez, ecnt);
    endtask

    task automatic rst_row();
        row(1, 0, 0, 0, 5'd0, 1, 0, 0, 0);
    endtask

    task automatic gap_row(input int ecnt);
        row(0, 0, 0, 0, 5'd0, 1, 0, 0, ecnt);
    endtask

    initial begin
        rst      = 1'b1;
        x_valid  = 1'b0;
        x        = 1'b0;
        pat_load = 1'b0;
        pat_in   = '0;
        overlap  = 1'b1;
        cnt_clr  = 1'b0;

        rst_row();
        // overlapping 1010101
        bit_row(1, 1, 0, 0); bit_row(0, 1, 0, 0); bit_row(1, 1, 0, 0);
        bit_row(0, 1, 0, 0); bit_row(1, 1, 1, 1); bit_row(0, 1, 0, 1);
        bit_row(1, 1, 1, 2);
        rst_row();
        // non-overlapping 1010101
        bit_row(1, 0, 0, 0); bit_row(0, 0, 0, 0); bit_row(1, 0, 0, 0);
        bit_row(0, 0, 0, 0); bit_row(1, 0, 1, 1); bit_row(0, 0, 0, 1);
        bit_row(1, 0, 0, 1);
        // all-zero pattern needs five fresh bits
        row(0, 0, 0, 1, 5'b00000, 1, 0, 0, 1);
        bit_row(0, 1, 0, 1); bit_row(0, 1, 0, 1); bit_row(0, 1, 0, 1);
        bit_row(0, 1, 0, 1); bit_row(0, 1, 1, 2);
        // load with a valid bit present discards the bit
        row(0, 1, 1, 1, 5'b00001, 1, 0, 0, 2);
        bit_row(0, 1, 0, 2); bit_row(0, 1, 0, 2); bit_row(0, 1, 0, 2);
        bit_row(0, 1, 0, 2); bit_row(1, 1, 1, 3);
        rst_row();
        // 10101 with invalid gaps
        bit_row(1, 1, 0, 0); gap_row(0); bit_row(0, 1, 0, 0); gap_row(0);
        gap_row(0); bit_row(1, 1, 0, 0); gap_row(0); bit_row(0, 1, 0, 0);
        gap_row(0); bit_row(1, 1, 1, 1); gap_row(1);
        row(0, 0, 0, 0, 5'd0, 1, 1, 0, 0);
        // reset mid-stream drops partial history
        bit_row(1, 1, 0, 0); bit_row(0, 1, 0, 0); bit_row(1, 1, 0, 0);
        rst_row();
        bit_row(0, 1, 0, 0); bit_row(1, 1, 0, 0);
        bit_row(1, 1, 0, 0); bit_row(0, 1, 0, 0); bit_row(1, 1, 0, 0);
        bit_row(0, 1, 0, 0); bit_row(1, 1, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            string tg;
            tg = $sformatf("tbl%0d", i);
            step(tg, tbl[i].r, tbl[i].xv, tbl[i].xb, tbl[i].pl,
                 tbl[i].pi, tbl[i].ov, tbl[i].cc);
            chk({tg, "_z_tab"}, 32'(z), 32'(tbl[i].ez));
            chk({tg, "_cnt_tab"}, 32'(match_cnt), 32'(tbl[i].ecnt));
        end

        for (int i = 0; i < 2000; i++) begin
            bit         r;
            bit         pl;
            bit         cc;
            logic [4:0] pi;
            r  = ($urandom_range(0, 199) == 0);
            pl = ($urandom_range(0, 49) == 0);
            cc = ($urandom_range(0, 39) == 0);
            pi = 5'($urandom);
            step("rnd", r, ($urandom_range(0, 3) != 0), 1'($urandom),
                 pl, pi, 1'($urandom), cc);
        end

        // saturate the counter with an all-ones stream
        step("sat_rst", 1, 0, 0, 0, 5'd0, 1, 0);
        step("sat_ld", 0, 0, 0, 1, 5'b11111, 1, 0);
        for (int i = 0; i < 262; i++) begin
            step("sat", 0, 1, 1, 0, 5'd0, 1, 0);
        end
        chk("sat_hold", 32'(match_cnt), 32'(CMAX));
        chk("sat_flag", 32'(cnt_sat), 32'(1));
        step("clr_hit", 0, 1, 1, 0, 5'd0, 1, 1);
        chk("clr_wins_z", 32'(z), 32'(1));
        chk("clr_wins_cnt", 32'(match_cnt), 32'(0));
        chk("clr_wins_sat", 32'(cnt_sat), 32'(0));
        step("post_clr", 0, 1, 1, 0, 5'd0, 1, 0);
        chk("post_clr_cnt", 32'(match_cnt), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
